// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 Hz raster timing (100 MHz clock, divide by 4) and shared counter/colour types.
package vga_timing_pkg;

   localparam int H_DISPLAY = 640;
   localparam int H_FP      = 16;
   localparam int H_SYNC    = 96;
   localparam int H_BP      = 48;
   localparam int V_DISPLAY = 480;
   localparam int V_FP      = 10;
   localparam int V_SYNC    = 2;
   localparam int V_BP      = 33;
   localparam int PIX_DIV   = 4;

   localparam int H_TOTAL   = H_DISPLAY + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL   = V_DISPLAY + V_FP + V_SYNC + V_BP;
   localparam int HS_START  = H_DISPLAY + H_FP;
   localparam int HS_END    = HS_START + H_SYNC - 1;
   localparam int VS_START  = V_DISPLAY + V_FP;
   localparam int VS_END    = VS_START + V_SYNC - 1;

   localparam int CNT_W     = 10;
   localparam int RGB_W     = 12;

   typedef logic [CNT_W-1:0] cnt_t;
   typedef logic [RGB_W-1:0] rgb_t;

   function automatic logic in_window(cnt_t v, int lo, int hi);
      return (int'(v) >= lo) && (int'(v) <= hi);
   endfunction

endpackage

// File: rtl/vga_sync_gen_if.sv
// Raster bundle between the sync generator (master) and the pixel-producing mechanism (slave).
interface vga_sync_gen_if;
   import vga_timing_pkg::*;

   rgb_t rgb_in;
   cnt_t x;
   cnt_t y;
   logic video_on;
   logic p_tick;
   logic frame_tick;
   logic hsync;
   logic vsync;
   rgb_t rgb_out;

   modport master (
      input  rgb_in,
      output x, y, video_on, p_tick, frame_tick, hsync, vsync, rgb_out
   );

   modport slave (
      output rgb_in,
      input  x, y, video_on, p_tick, frame_tick, hsync, vsync, rgb_out
   );
endinterface

// File: rtl/pixel_tick_gen.sv
// Pixel clock enable: one-clk p_tick every PIX_DIV clocks (PIX_DIV >= 2).
// First tick PIX_DIV clocks after reset release; free-running, no backpressure.
module pixel_tick_gen #(
   parameter int PIX_DIV = vga_timing_pkg::PIX_DIV
) (
   input  logic clk,
   input  logic reset,
   output logic p_tick
);
   localparam int W = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
   localparam logic [W-1:0] LAST = W'(PIX_DIV - 1);

   logic [W-1:0] div_q;

   assign p_tick = (div_q == LAST);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         div_q <= '0;
      end else if (p_tick) begin
         div_q <= '0;
      end else begin
         div_q <= div_q + W'(1);
      end
   end
endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster generator: x/y/video_on/ticks live from the counters; hsync, vsync and rgb_out
// are registered and trail x/y by one pixel period, mutually aligned. No backpressure.
module vga_sync_gen #(
   parameter int H_DISPLAY = vga_timing_pkg::H_DISPLAY,
   parameter int H_FP      = vga_timing_pkg::H_FP,
   parameter int H_SYNC    = vga_timing_pkg::H_SYNC,
   parameter int H_BP      = vga_timing_pkg::H_BP,
   parameter int V_DISPLAY = vga_timing_pkg::V_DISPLAY,
   parameter int V_FP      = vga_timing_pkg::V_FP,
   parameter int V_SYNC    = vga_timing_pkg::V_SYNC,
   parameter int V_BP      = vga_timing_pkg::V_BP,
   parameter int PIX_DIV   = vga_timing_pkg::PIX_DIV
) (
   input  logic           clk,
   input  logic           reset,
   vga_sync_gen_if.master vga
);
   localparam int H_TOTAL  = H_DISPLAY + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL  = V_DISPLAY + V_FP + V_SYNC + V_BP;
   localparam int HS_START = H_DISPLAY + H_FP;
   localparam int HS_END   = HS_START + H_SYNC - 1;
   localparam int VS_START = V_DISPLAY + V_FP;
   localparam int VS_END   = VS_START + V_SYNC - 1;

   localparam vga_timing_pkg::cnt_t X_LAST = 10'(H_TOTAL - 1);
   localparam vga_timing_pkg::cnt_t Y_LAST = 10'(V_TOTAL - 1);
   localparam vga_timing_pkg::cnt_t X_VIS  = 10'(H_DISPLAY);
   localparam vga_timing_pkg::cnt_t Y_VIS  = 10'(V_DISPLAY);

   vga_timing_pkg::cnt_t x_q;
   vga_timing_pkg::cnt_t y_q;
   vga_timing_pkg::rgb_t rgb_q;
   logic                 hsync_q;
   logic                 vsync_q;
   logic                 p_tick;
   logic                 video_on;

   pixel_tick_gen #(.PIX_DIV(PIX_DIV)) u_tick (
      .clk    (clk),
      .reset  (reset),
      .p_tick (p_tick)
   );

   assign video_on = (x_q < X_VIS) && (y_q < Y_VIS);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         x_q     <= '0;
         y_q     <= '0;
         hsync_q <= 1'b1;
         vsync_q <= 1'b1;
         rgb_q   <= '0;
      end else if (p_tick) begin
         // Output stage samples the pre-increment position: one pixel period of latency.
         hsync_q <= ~vga_timing_pkg::in_window(x_q, HS_START, HS_END);
         vsync_q <= ~vga_timing_pkg::in_window(y_q, VS_START, VS_END);
         rgb_q   <= video_on ? vga.rgb_in : '0;
         if (x_q == X_LAST) begin
            x_q <= '0;
            y_q <= (y_q == Y_LAST) ? '0 : y_q + 10'd1;
         end else begin
            x_q <= x_q + 10'd1;
         end
      end
   end

   assign vga.x          = x_q;
   assign vga.y          = y_q;
   assign vga.video_on   = video_on;
   assign vga.p_tick     = p_tick;
   assign vga.frame_tick = p_tick && (x_q == X_LAST) && (y_q == Y_LAST);
   assign vga.hsync      = hsync_q;
   assign vga.vsync      = vsync_q;
   assign vga.rgb_out    = rgb_q;
endmodule
